// File: rtl/pref_issue_arb_if.sv
// Candidate bus from the prefetcher plus the issue handshake toward memory.
interface pref_issue_arb_if #(
    parameter int unsigned ADDR_W = 64
);
    logic [ADDR_W-1:0] pref_addr1_i;
    logic [ADDR_W-1:0] pref_addr2_i;
    logic [ADDR_W-1:0] pref_addr3_i;
    logic              pref_valid1_i;
    logic              pref_valid2_i;
    logic              pref_valid3_i;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_valid_o;
    logic              req_ready_i;

    // Prefetcher side plus the downstream memory port.
    modport master (
        output pref_addr1_i, pref_addr2_i, pref_addr3_i,
        output pref_valid1_i, pref_valid2_i, pref_valid3_i,
        output req_ready_i,
        input  req_addr_o, req_valid_o
    );

    // Arbiter side.
    modport slave (
        input  pref_addr1_i, pref_addr2_i, pref_addr3_i,
        input  pref_valid1_i, pref_valid2_i, pref_valid3_i,
        input  req_ready_i,
        output req_addr_o, req_valid_o
    );
endinterface

// File: rtl/pref_issue_arb.sv
// Prefetch issue arbiter: dedupes up to three candidates per cycle against
// each other and the pending queue, buffers survivors in a circular FIFO and
// issues line-aligned requests one per handshake.
module pref_issue_arb #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned LINE_BITS = 6,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    pref_issue_arb_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic [15:0]                  drop_cnt_o
);
    localparam int unsigned LINE_W = ADDR_W - LINE_BITS;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned NSLOT  = 3;

    logic [LINE_W-1:0] line_q [DEPTH];
    logic [LINE_W-1:0] line_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       drop_q, drop_d;

    logic [LINE_W-1:0] cand_line [NSLOT];
    logic [NSLOT-1:0]  cand_vld;
    logic              pop;
    logic [CNT_W-1:0]  avail;
    logic [CNT_W-1:0]  pushes;
    logic              dup;
    logic [PTR_W-1:0]  wptr;

    // Line offsets of the candidates never matter for dedupe or issue.
    logic unused_offsets;
    assign unused_offsets = ^{bus.pref_addr1_i[LINE_BITS-1:0],
                              bus.pref_addr2_i[LINE_BITS-1:0],
                              bus.pref_addr3_i[LINE_BITS-1:0]};

    // Next-state: pop at head, filter candidates, enqueue in slot order, count capacity drops.
    always_comb begin
        line_d  = line_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = drop_q;
        pushes  = '0;
        dup     = 1'b0;
        wptr    = '0;

        cand_line[0] = bus.pref_addr1_i[ADDR_W-1:LINE_BITS];
        cand_line[1] = bus.pref_addr2_i[ADDR_W-1:LINE_BITS];
        cand_line[2] = bus.pref_addr3_i[ADDR_W-1:LINE_BITS];
        cand_vld     = {bus.pref_valid3_i, bus.pref_valid2_i, bus.pref_valid1_i};

        pop   = (count_q != '0) && bus.req_ready_i;
        avail = CNT_W'(DEPTH) - count_q + CNT_W'(pop);

        if (flush_i) begin
            vld_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + PTR_W'(1);
            end
            for (int s = 0; s < int'(NSLOT); s++) begin
                dup = 1'b0;
                for (int p = 0; p < s; p++) begin
                    if (cand_vld[p] && (cand_line[p] == cand_line[s])) dup = 1'b1;
                end
                // Compare against pre-pop state so the head being issued still filters.
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if (vld_q[e] && (line_q[e] == cand_line[s])) dup = 1'b1;
                end
                if (cand_vld[s] && !dup) begin
                    if (pushes < avail) begin
                        wptr         = tail_q + PTR_W'(pushes);
                        line_d[wptr] = cand_line[s];
                        vld_d[wptr]  = 1'b1;
                        pushes       = pushes + CNT_W'(1);
                    end else if (drop_d != 16'hFFFF) begin
                        drop_d = drop_d + 16'd1;
                    end
                end
            end
            tail_d  = tail_q + PTR_W'(pushes);
            count_d = count_q - CNT_W'(pop) + pushes;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= '{default: '0};
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            line_q  <= line_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs decode registered state only.
    assign bus.req_valid_o = (count_q != '0);
    assign bus.req_addr_o  = {line_q[head_q], {LINE_BITS{1'b0}}};
    assign occupancy_o     = count_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_pref_issue_arb.sv
// Directed bench for pref_issue_arb with an issue-order scoreboard.
module tb_pref_issue_arb;
    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [3:0]  occupancy_o;
    logic [15:0] drop_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    pref_issue_arb_if #(.ADDR_W(64)) bus ();

    pref_issue_arb #(.ADDR_W(64), .LINE_BITS(6), .DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .bus         (bus.slave),
        .occupancy_o (occupancy_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_c(input logic [63:0] a1, input logic v1,
                         input logic [63:0] a2, input logic v2,
                         input logic [63:0] a3, input logic v3);
        bus.pref_addr1_i  = a1; bus.pref_valid1_i = v1;
        bus.pref_addr2_i  = a2; bus.pref_valid2_i = v2;
        bus.pref_addr3_i  = a3; bus.pref_valid3_i = v3;
    endtask

    // Score any handshake about to complete, then advance one edge.
    task automatic cycle();
        logic [63:0] e;
        if (bus.req_valid_o && bus.req_ready_i && !flush_i && rst_n) begin
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL issue_unexpected: observed 0x%0h expected no issue", bus.req_addr_o);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_order", bus.req_addr_o, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        bus.req_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
        chk(tag, 64'(exp_q.size()), 64'd0);
        chk({tag, "_occ"}, 64'(occupancy_o), 64'd0);
        chk({tag, "_valid"}, 64'(bus.req_valid_o), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        bus.req_ready_i = 1'b0;
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        #1;
        chk("rst_valid", 64'(bus.req_valid_o), 64'd0);
        chk("rst_addr", bus.req_addr_o, 64'd0);
        chk("rst_occ", 64'(occupancy_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single issue; a same-line candidate during the head pop is a duplicate.
        bus.req_ready_i = 1'b1;
        set_c(64'h1010, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        exp_q.push_back(64'h1000);
        cycle();
        set_c(64'h1020, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("single_valid", 64'(bus.req_valid_o), 64'd1);
        chk("single_addr", bus.req_addr_o, 64'h1000);
        chk("single_occ", 64'(occupancy_o), 64'd1);
        cycle();
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("single_after_valid", 64'(bus.req_valid_o), 64'd0);
        chk("single_after_occ", 64'(occupancy_o), 64'd0);

        // Dedupe within a cycle and against the queue.
        bus.req_ready_i = 1'b0;
        set_c(64'h1000, 1'b1, 64'h1038, 1'b1, 64'h2000, 1'b1);
        exp_q.push_back(64'h1000);
        exp_q.push_back(64'h2000);
        cycle();
        set_c(64'h2004, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        cycle();
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("dedupe_occ", 64'(occupancy_o), 64'd2);
        chk("dedupe_drop", 64'(drop_cnt_o), 64'd0);
        chk("dedupe_head", bus.req_addr_o, 64'h1000);
        drain("dedupe_drain");

        // Overflow: nine unique lines, the last one dropped; tail wraps through 0.
        bus.req_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_c(64'h10000 + 64'((c*3+0)*64), 1'b1,
                  64'h10000 + 64'((c*3+1)*64), 1'b1,
                  64'h10000 + 64'((c*3+2)*64), 1'b1);
            for (int s = 0; s < 3; s++)
                if (c*3+s < 8) exp_q.push_back(64'h10000 + 64'((c*3+s)*64));
            cycle();
            chk("ovf_hold_addr", bus.req_addr_o, 64'h10000);
        end
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("ovf_occ", 64'(occupancy_o), 64'd8);
        chk("ovf_drop", 64'(drop_cnt_o), 64'd1);
        cycle();
        chk("ovf_stall_addr", bus.req_addr_o, 64'h10000);
        chk("ovf_stall_valid", 64'(bus.req_valid_o), 64'd1);

        // Full queue with a pop: one of two survivors accepted.
        bus.req_ready_i = 1'b1;
        set_c(64'h20000, 1'b1, 64'h20040, 1'b1, 64'h0, 1'b0);
        exp_q.push_back(64'h20000);
        cycle();
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("fullpop_occ", 64'(occupancy_o), 64'd8);
        chk("fullpop_drop", 64'(drop_cnt_o), 64'd2);
        drain("fullpop_drain");

        // Flush with a candidate and a ready downstream.
        bus.req_ready_i = 1'b0;
        set_c(64'h30000, 1'b1, 64'h30040, 1'b1, 64'h30080, 1'b1);
        cycle();
        set_c(64'h300C0, 1'b1, 64'h30100, 1'b1, 64'h0, 1'b0);
        cycle();
        chk("flush_pre_occ", 64'(occupancy_o), 64'd5);
        flush_i = 1'b1;
        bus.req_ready_i = 1'b1;
        set_c(64'h40000, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        cycle();
        flush_i = 1'b0;
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("flush_occ", 64'(occupancy_o), 64'd0);
        chk("flush_valid", 64'(bus.req_valid_o), 64'd0);
        chk("flush_drop", 64'(drop_cnt_o), 64'd2);
        cycle();
        chk("flush_no_enq", 64'(occupancy_o), 64'd0);

        // Asynchronous reset mid-cycle with three entries queued.
        bus.req_ready_i = 1'b0;
        set_c(64'h50000, 1'b1, 64'h50040, 1'b1, 64'h50080, 1'b1);
        cycle();
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("mid_pre_occ", 64'(occupancy_o), 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.req_valid_o), 64'd0);
        chk("mid_rst_occ", 64'(occupancy_o), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
        chk("mid_rst_addr", bus.req_addr_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_valid", 64'(bus.req_valid_o), 64'd0);
        chk("post_rst_occ", 64'(occupancy_o), 64'd0);
        bus.req_ready_i = 1'b1;
        set_c(64'h60008, 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        exp_q.push_back(64'h60000);
        cycle();
        set_c(64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        chk("post_rst_enq_valid", 64'(bus.req_valid_o), 64'd1);
        chk("post_rst_enq_addr", bus.req_addr_o, 64'h60000);
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pref_issue_arb.md
# pref_issue_arb

Prefetch issue arbiter between the `ip_stride` prefetcher and the lower-level memory request port. Each cycle it accepts up to three candidate prefetch addresses from the prefetcher's three output slots. It drops candidates that fall in a cache line already pending, buffers the rest in a circular FIFO, and issues them one at a time over a valid/ready handshake. Candidates that arrive when the buffer is full are dropped and counted.

## Interface
- `ADDR_W`, 64, address width.
- `LINE_BITS`, 6, cache-line offset bits. Line address = addr >> LINE_BITS.
- `DEPTH`, 8, FIFO entries. Power of two, ≥ 4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pref_addr1_i` / `pref_addr2_i` / `pref_addr3_i`  in  ADDR_W each  candidate addresses from prefetcher slots 1/2/3.
- `pref_valid1_i` / `pref_valid2_i` / `pref_valid3_i`  in  1 each  candidate valid for the matching slot.
- `flush_i`  in  1  synchronous clear of the queue.
- `req_addr_o`  out  ADDR_W  line-aligned issue address (low LINE_BITS bits = 0).
- `req_valid_o`  out  1  issue request valid.
- `req_ready_i`  in  1  downstream accepts the request.
- `occupancy_o`  out  $clog2(DEPTH+1)  current number of entries in the queue.
- `drop_cnt_o`  out  16  saturating count of candidates dropped for capacity.

## Operation
- **Storage.** DEPTH line addresses plus per-entry valid bits, a head pointer, a tail pointer and a count. Pointers wrap modulo DEPTH.
- **Issue.**
  - `req_valid_o` = (count != 0).
  - `req_addr_o` = head line << LINE_BITS.
  - Pop occurs when `req_valid_o & req_ready_i`.
  - While `req_valid_o & !req_ready_i`, `req_addr_o` holds stable.
- **Candidate filtering** runs on slots 1, 2, 3 in that priority order. A valid candidate is discarded as a duplicate (not counted) when its line matches either of these:
  - the line of a lower-numbered valid slot in the same cycle;
  - the line of any valid queue entry, including the head entry being popped this cycle.
- **Enqueue.**
  - Surviving candidates are written in slot order at tail, tail+1, …
  - Available space = DEPTH − count + (pop this cycle ? 1 : 0).
  - Survivors beyond available space are dropped. Each such drop increments `drop_cnt_o` by 1, saturating at 16'hFFFF.
- **Count update.** count_next = count − pop + pushes. It never exceeds DEPTH.
- **Flush.** When `flush_i` = 1 at an edge:
  - count, head and tail are set to 0 and all entries are invalidated;
  - candidates and the pop in that cycle are ignored;
  - `drop_cnt_o` is unchanged.
- **Reset.** While `rst_n` = 0:
  - `req_valid_o` = 0, `req_addr_o` = 0, `occupancy_o` = 0, `drop_cnt_o` = 0;
  - all pointers and valid bits are 0.
  - Assertion takes effect immediately, independent of `clk`, and aborts any pending handshake.
- **No combinational paths** from `pref_*_i` or `req_ready_i` to any output.

## Timing
- **Enqueue latency** is 1 cycle. A candidate sampled at edge N into an empty queue produces `req_valid_o` = 1 with its address after edge N.
- **Throughput.**
  - Up to 3 enqueues per cycle.
  - 1 issue per cycle when `req_ready_i` is held high.
- **Full queue with pop.** When count = DEPTH and a pop occurs in the same cycle, exactly one survivor can be accepted.
- **Empty queue.** Pop cannot occur when count = 0 because `req_valid_o` = 0. Candidates go straight to the empty FIFO; there is no bypass.
- **Output timing.** `occupancy_o` and `drop_cnt_o` reflect the state after the last edge.
- **Release from reset.** `rst_n` release is synchronous to `clk` by the system. The first enqueue can happen at the first edge after release.

## Test plan
- **Reset.**
  - Pulse `rst_n` low mid-cycle while the queue holds 3 entries.
  - Required: `req_valid_o`, `occupancy_o` and `drop_cnt_o` go to 0 before the next edge and stay 0 until the first post-reset enqueue.
- **Single issue.**
  - Drive slot1 = 0x1010 valid for one cycle, `req_ready_i` = 1.
  - Required: the next cycle shows `req_valid_o` = 1 and `req_addr_o` = 0x1000.
  - The cycle after that shows `req_valid_o` = 0 and `occupancy_o` = 0.
- **Dedupe.**
  - With `req_ready_i` = 0, drive slots = 0x1000, 0x1038, 0x2000 in one cycle.
  - Next cycle, drive slot1 = 0x2004.
  - Required: `occupancy_o` = 2, issue order 0x1000 then 0x2000, `drop_cnt_o` = 0.
- **Overflow.**
  - With `req_ready_i` = 0, push 3 unique lines per cycle for 3 cycles (9 candidates).
  - Required: `occupancy_o` = 8 and `drop_cnt_o` = 1.
  - The dropped candidate is cycle 3, slot 3.
  - Drain order equals insertion order; tail wraps through index 0.
- **Full + pop.**
  - Queue full, `req_ready_i` = 1, drive 2 unique candidates.
  - Required: 1 accepted, `occupancy_o` stays 8, `drop_cnt_o` += 1.
  - `req_addr_o` is held stable in the preceding cycles while `req_ready_i` was 0.
- **Flush.**
  - Queue holds 5 entries; assert `flush_i` together with a valid slot1 candidate and `req_ready_i` = 1.
  - Required: `occupancy_o` = 0 and `req_valid_o` = 0 next cycle, the candidate is not enqueued, and `drop_cnt_o` is unchanged.
